// File: rtl/riscv_mem_responder.sv
// Memory-side responder for the Riscv141 icache/dcache request ports.
// Serialises a fetch and a data access onto one valid/ready backing-memory port.
// While a request is being serviced, stall is held high.
module riscv_mem_responder #(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              icache_re,
    output logic [31:0]       icache_dout,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic              dcache_re,
    input  logic [3:0]        dcache_we,
    input  logic [31:0]       dcache_din,
    output logic [31:0]       dcache_dout,
    output logic              stall,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [3:0]        mem_req_we,
    output logic [31:0]       mem_req_data,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data,
    output logic              mem_timeout
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam int unsigned WA_W  = ADDR_W - 2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_I = 3'd1,
        WAIT_I  = 3'd2,
        ISSUE_D = 3'd3,
        WAIT_D  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic              d_req_q, d_req_d;
    logic [WA_W-1:0]   i_addr_q, i_addr_d;
    logic [WA_W-1:0]   d_addr_q, d_addr_d;
    logic [3:0]        d_we_q, d_we_d;
    logic [31:0]       d_din_q, d_din_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic [31:0]       idout_q, idout_d;
    logic [31:0]       ddout_q, ddout_d;
    logic              req_valid_q, req_valid_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [3:0]        req_we_q, req_we_d;
    logic [31:0]       req_data_q, req_data_d;
    logic              stall_q, stall_d;

    logic              d_req_c;
    logic              waiting_c;
    logic              unused_addr_bits;

    // Low address bits are dropped: the backing memory is word addressed.
    assign unused_addr_bits = ^{icache_addr[1:0], dcache_addr[1:0]};

    assign d_req_c = dcache_re | (|dcache_we);

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            d_req_q     <= 1'b0;
            i_addr_q    <= '0;
            d_addr_q    <= '0;
            d_we_q      <= '0;
            d_din_q     <= '0;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            idout_q     <= '0;
            ddout_q     <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_we_q    <= '0;
            req_data_q  <= '0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_req_q     <= d_req_d;
            i_addr_q    <= i_addr_d;
            d_addr_q    <= d_addr_d;
            d_we_q      <= d_we_d;
            d_din_q     <= d_din_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
            idout_q     <= idout_d;
            ddout_q     <= ddout_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_we_q    <= req_we_d;
            req_data_q  <= req_data_d;
            stall_q     <= stall_d;
        end
    end

    // Next-state, request capture, watchdog and registered output values.
    always_comb begin
        state_d    = state_q;
        d_req_d    = d_req_q;
        i_addr_d   = i_addr_q;
        d_addr_d   = d_addr_q;
        d_we_d     = d_we_q;
        d_din_d    = d_din_q;
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
        idout_d    = idout_q;
        ddout_d    = ddout_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        req_we_d   = '0;
        waiting_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (icache_re || d_req_c) begin
                    i_addr_d = icache_addr[ADDR_W-1:2];
                    d_addr_d = dcache_addr[ADDR_W-1:2];
                    d_we_d   = dcache_we;
                    d_din_d  = dcache_din;
                    d_req_d  = d_req_c;
                end
                if (icache_re) begin
                    state_d = ISSUE_I;
                end else if (d_req_c) begin
                    state_d = ISSUE_D;
                end
            end
            ISSUE_I: begin
                if (mem_req_ready) begin
                    state_d = WAIT_I;
                    cnt_d   = '0;
                end
            end
            WAIT_I: begin
                if (mem_resp_valid) begin
                    idout_d = mem_resp_data;
                    state_d = d_req_q ? ISSUE_D : IDLE;
                end else begin
                    waiting_c = 1'b1;
                end
            end
            ISSUE_D: begin
                if (mem_req_ready) begin
                    state_d = WAIT_D;
                    cnt_d   = '0;
                end
            end
            WAIT_D: begin
                if (mem_resp_valid) begin
                    if (d_we_q == 4'b0000) begin
                        ddout_d = mem_resp_data;
                    end
                    d_req_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    waiting_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Watchdog: saturating count of response-less WAIT cycles, sticky flag.
        if (waiting_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == (CNT_MAX - CNT_W'(1))) begin
                timeout_d = 1'b1;
            end
        end

        req_valid_d = (state_d == ISSUE_I) || (state_d == ISSUE_D);
        if (state_d == ISSUE_I) begin
            req_addr_d = {i_addr_d, 2'b00};
        end else if (state_d == ISSUE_D) begin
            req_addr_d = {d_addr_d, 2'b00};
            req_we_d   = d_we_d;
            req_data_d = d_din_d;
        end
        stall_d = (state_d != IDLE);
    end

    assign icache_dout   = idout_q;
    assign dcache_dout   = ddout_q;
    assign stall         = stall_q;
    assign mem_req_valid = req_valid_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_we    = req_we_q;
    assign mem_req_data  = req_data_q;
    assign mem_timeout   = timeout_q;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Self-checking bench for riscv_mem_responder with a behavioural backing-memory model.
module tb_riscv_mem_responder;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned MAX_WAIT = 255;

    logic        clk;
    logic        reset;
    logic [31:0] icache_addr, dcache_addr, dcache_din, mem_resp_data;
    logic        icache_re, dcache_re, mem_req_ready, mem_resp_valid;
    logic [3:0]  dcache_we;
    logic [31:0] icache_dout, dcache_dout, mem_req_addr, mem_req_data;
    logic [3:0]  mem_req_we;
    logic        stall, mem_req_valid, mem_timeout;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_idout = '0;
    logic [31:0] exp_ddout = '0;
    int to_first;

    riscv_mem_responder #(.MAX_WAIT(MAX_WAIT), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .icache_addr(icache_addr), .icache_re(icache_re), .icache_dout(icache_dout),
        .dcache_addr(dcache_addr), .dcache_re(dcache_re), .dcache_we(dcache_we),
        .dcache_din(dcache_din), .dcache_dout(dcache_dout), .stall(stall),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_req_data(mem_req_data),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .mem_timeout(mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One CPU transaction: called at a negedge with stall low, returns at the negedge stall falls.
    // r = cycles ready is held low per access, d = extra cycles before the response.
    task automatic do_txn(input logic ire, input logic [31:0] ia, input logic dre,
                          input logic [3:0] dwe, input logic [31:0] da, input logic [31:0] din,
                          input int r, input int d, input logic [31:0] rd0,
                          input logic [31:0] rd1, input string nm);
        logic [31:0] ea[$];
        logic [3:0]  ew[$];
        logic [31:0] ed[$];
        logic [31:0] rq[$];
        int  n_acc, exp_stall, stall_cnt, rdy_cnt, resp_cnt, k;
        bit  resp_pending, done, tmo_prev;
        n_acc = 0;
        if (ire) begin
            ea.push_back({ia[31:2], 2'b00}); ew.push_back(4'b0000); ed.push_back(32'h0);
            rq.push_back(rd0); exp_idout = rd0; n_acc++;
        end
        if (dre || (dwe != 4'b0000)) begin
            ea.push_back({da[31:2], 2'b00}); ew.push_back(dwe); ed.push_back(din);
            rq.push_back(rd1); if (dwe == 4'b0000) exp_ddout = rd1; n_acc++;
        end
        exp_stall = n_acc * (2 + r + d);
        icache_re = ire; icache_addr = ia; dcache_re = dre; dcache_we = dwe;
        dcache_addr = da; dcache_din = din;
        stall_cnt = 0; rdy_cnt = r; resp_pending = 0; resp_cnt = 0; k = 0; done = 0;
        tmo_prev = mem_timeout; to_first = -1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
            if (!stall) begin done = 1; break; end
            stall_cnt++;
            if (mem_timeout && !tmo_prev && to_first < 0) to_first = stall_cnt;
            if (resp_pending) begin
                checks++;
                if (mem_req_valid !== 1'b0) begin
                    errors++; $display("FAIL %s valid_in_wait: got %b want 0", nm, mem_req_valid);
                end
                if (resp_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data = (rq.size() > 0) ? rq.pop_front() : 32'h0;
                    resp_pending = 0;
                end else begin
                    resp_cnt--;
                end
            end else if (mem_req_valid) begin
                checks++;
                if (k >= n_acc) begin
                    errors++; $display("FAIL %s extra_req: got addr %h want none", nm, mem_req_addr);
                end else if (mem_req_addr !== ea[k] || mem_req_we !== ew[k] ||
                             (ew[k] != 4'b0000 && mem_req_data !== ed[k])) begin
                    errors++;
                    $display("FAIL %s req%0d: got addr %h we %b data %h want addr %h we %b data %h",
                             nm, k, mem_req_addr, mem_req_we, mem_req_data, ea[k], ew[k], ed[k]);
                end
                if (rdy_cnt == 0) begin
                    mem_req_ready = 1'b1; k++; resp_pending = 1; resp_cnt = d; rdy_cnt = r;
                end else begin
                    rdy_cnt--;
                end
            end
        end
        icache_re = 1'b0; dcache_re = 1'b0; dcache_we = 4'b0000;
        checks++;
        if (!done) begin errors++; $display("FAIL %s timeout: stall still high after bound", nm); end
        checks++;
        if (stall_cnt != exp_stall) begin
            errors++; $display("FAIL %s stall_cycles: got %0d want %0d", nm, stall_cnt, exp_stall);
        end
        checks++;
        if (k != n_acc) begin errors++; $display("FAIL %s accesses: got %0d want %0d", nm, k, n_acc); end
        checks++;
        if (icache_dout !== exp_idout) begin
            errors++; $display("FAIL %s icache_dout: got %h want %h", nm, icache_dout, exp_idout);
        end
        checks++;
        if (dcache_dout !== exp_ddout) begin
            errors++; $display("FAIL %s dcache_dout: got %h want %h", nm, dcache_dout, exp_ddout);
        end
        checks++;
        if (mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL %s valid_after: got %b want 0", nm, mem_req_valid);
        end
    endtask

    task automatic check_all_zero(input string nm);
        checks++;
        if ({icache_dout, dcache_dout, stall, mem_req_valid, mem_req_we, mem_req_addr,
             mem_req_data, mem_timeout} !== '0) begin
            errors++;
            $display("FAIL %s outputs: got id %h dd %h st %b v %b we %b a %h d %h to %b want all 0",
                     nm, icache_dout, dcache_dout, stall, mem_req_valid, mem_req_we,
                     mem_req_addr, mem_req_data, mem_timeout);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            icache_addr = $urandom; icache_re = 1'($urandom); dcache_addr = $urandom;
            dcache_re = 1'($urandom); dcache_we = 4'($urandom); dcache_din = $urandom;
            mem_req_ready = 1'($urandom); mem_resp_valid = 1'($urandom); mem_resp_data = $urandom;
        end
        @(negedge clk);
        check_all_zero("reset");
        icache_re = 0; dcache_re = 0; dcache_we = 0; mem_req_ready = 0; mem_resp_valid = 0;
        reset = 1'b1;
        exp_idout = '0; exp_ddout = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (stall !== 1'b0 || mem_req_valid !== 1'b0) begin
                errors++; $display("FAIL idle_after_reset: got stall %b valid %b want 0 0", stall, mem_req_valid);
            end
        end
    endtask

    task automatic test_fetch_only();
        do_txn(1, 32'h1006, 0, 4'b0000, 32'h0, 32'h0, 0, 0, 32'h00A00093, 32'h0, "fetch_only");
        checks++;
        if (icache_dout !== 32'h00A00093) begin
            errors++; $display("FAIL fetch_value: got %h want 00a00093", icache_dout);
        end
    endtask

    task automatic test_fetch_store();
        do_txn(1, 32'h2000, 0, 4'b0011, 32'h3002, 32'hDEADBEEF, 0, 0, $urandom, $urandom, "fetch_store");
    endtask

    task automatic test_load_ready_low();
        do_txn(0, 32'h0, 1, 4'b0000, $urandom, $urandom, 3, 0, 32'h0, $urandom | 32'h1, "load_ready_low");
    endtask

    task automatic test_stray_resp();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_resp_valid = 1'b1; mem_resp_data = $urandom;
        end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        checks++;
        if (icache_dout !== exp_idout || dcache_dout !== exp_ddout || stall !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_resp: got id %h dd %h st %b v %b want id %h dd %h st 0 v 0",
                     icache_dout, dcache_dout, stall, mem_req_valid, exp_idout, exp_ddout);
        end
    endtask

    task automatic test_random();
        logic [3:0] we;
        for (int i = 0; i < 24; i++) begin
            we = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            do_txn(1'($urandom), $urandom, 1'($urandom), we, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom, "random");
        end
        checks++;
        if (mem_timeout !== 1'b0) begin errors++; $display("FAIL no_timeout: got %b want 0", mem_timeout); end
    endtask

    task automatic test_timeout();
        do_txn(1, $urandom, 0, 4'b0000, 32'h0, 32'h0, 0, MAX_WAIT + 5, $urandom, 32'h0, "timeout_wait");
        checks++;
        if (to_first != int'(2 + MAX_WAIT)) begin
            errors++; $display("FAIL timeout_cycle: got %0d want %0d", to_first, 2 + MAX_WAIT);
        end
        do_txn(0, 32'h0, 1, 4'b0000, $urandom, 32'h0, 0, 0, 32'h0, $urandom | 32'h1, "after_timeout");
        checks++;
        if (mem_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", mem_timeout); end
    endtask

    task automatic test_reset_in_wait();
        dcache_re = 1'b1; dcache_addr = $urandom;
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rst_wait_issue: got %b want 1", mem_req_valid); end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0; dcache_re = 1'b0;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL rst_wait_stall: got %b want 1", stall); end
        reset = 1'b0;
        #1;
        check_all_zero("reset_in_wait");
        exp_idout = '0; exp_ddout = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b1; mem_resp_data = $urandom | 32'h1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (stall !== 1'b0 || mem_req_valid !== 1'b0 || dcache_dout !== 32'h0 || icache_dout !== 32'h0) begin
                errors++;
                $display("FAIL late_resp: got st %b v %b dd %h id %h want 0 0 0 0",
                         stall, mem_req_valid, dcache_dout, icache_dout);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        icache_addr = '0; icache_re = 0; dcache_addr = '0; dcache_re = 0; dcache_we = '0;
        dcache_din = '0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        test_reset();
        test_fetch_only();
        test_fetch_store();
        test_load_ready_low();
        test_stray_resp();
        test_random();
        test_timeout();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
